// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op-code encoding, default
// latencies and the op-class decode used by the top-level controller.
// Optional feature macro: MD_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
package md_pkg;

  localparam logic [3:0] MD_NONE = 4'd0;
  localparam logic [3:0] MULT    = 4'd1;
  localparam logic [3:0] MULTU   = 4'd2;
  localparam logic [3:0] DIV     = 4'd3;
  localparam logic [3:0] DIVU    = 4'd4;
  localparam logic [3:0] MTHI    = 4'd5;
  localparam logic [3:0] MTLO    = 4'd6;
  localparam logic [3:0] MADD    = 4'd7;
  localparam logic [3:0] MADDU   = 4'd8;
  localparam logic [3:0] MSUB    = 4'd9;
  localparam logic [3:0] MSUBU   = 4'd10;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // What the controller has to do with an op: nothing, a timed multiply-type
  // op, a timed divide, or an immediate HI/LO move.
  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_MUL  = 3'd1,
    CLS_DIV  = 3'd2,
    CLS_MTHI = 3'd3,
    CLS_MTLO = 3'd4
  } md_cls_e;

  function automatic md_cls_e md_classify(input logic [3:0] op);
    md_cls_e cls;
    case (op)
      MULT, MULTU: cls = CLS_MUL;
      DIV, DIVU:   cls = CLS_DIV;
      MTHI:        cls = CLS_MTHI;
      MTLO:        cls = CLS_MTLO;
`ifdef MD_MADD_EN
      MADD, MADDU, MSUB, MSUBU: cls = CLS_MUL;
`endif
      default:     cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational datapath of the multiply/divide unit: produces the 64-bit
// {HI,LO} result for the op being launched. Division is done on magnitudes so
// that -2^31 / -1 and truncation toward zero fall out without special cases.
// Optional feature macro: MD_MADD_EN (accumulate onto current HI/LO).
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  iop,
  input  logic [31:0] iA1,
  input  logic [31:0] iA2,
  input  logic [31:0] iHI,
  input  logic [31:0] iLO,
  output logic [63:0] ores,
  output logic        odiv_zero
);

  logic [63:0] prod_s_s;
  logic [63:0] prod_u_s;
  logic        sdiv_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] b_safe_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

`ifndef MD_MADD_EN
  // HI/LO only feed the accumulate path; keep them referenced when it is absent.
  logic unused_acc_s;
  assign unused_acc_s = ^{iHI, iLO};
`endif

  // Products, divide magnitudes and final result selection for the op.
  always_comb begin
    prod_s_s = {{32{iA1[31]}}, iA1} * {{32{iA2[31]}}, iA2};
    prod_u_s = {32'd0, iA1} * {32'd0, iA2};

    sdiv_s   = (iop == DIV);
    a_mag_s  = (sdiv_s && iA1[31]) ? (32'd0 - iA1) : iA1;
    b_mag_s  = (sdiv_s && iA2[31]) ? (32'd0 - iA2) : iA2;
    // A zero divisor is replaced so the divider never sees it; the result is
    // discarded by the controller in that case.
    b_safe_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
    q_mag_s  = a_mag_s / b_safe_s;
    r_mag_s  = a_mag_s % b_safe_s;
    quo_s    = (sdiv_s && (iA1[31] ^ iA2[31])) ? (32'd0 - q_mag_s) : q_mag_s;
    rem_s    = (sdiv_s && iA1[31]) ? (32'd0 - r_mag_s) : r_mag_s;

    odiv_zero = (iA2 == 32'd0);

    case (iop)
      MULT:      ores = prod_s_s;
      MULTU:     ores = prod_u_s;
      DIV, DIVU: ores = {rem_s, quo_s};
`ifdef MD_MADD_EN
      MADD:      ores = {iHI, iLO} + prod_s_s;
      MADDU:     ores = {iHI, iLO} + prod_u_s;
      MSUB:      ores = {iHI, iLO} - prod_s_s;
      MSUBU:     ores = {iHI, iLO} - prod_u_s;
`endif
      default:   ores = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_iter_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. The result is
// computed at launch and held pending; a down-counter models the iterative
// latency and HI/LO are written on the edge where the counter reaches zero.
// Optional feature macro: MD_MADD_EN (MADD/MADDU/MSUB/MSUBU).
module md_iter_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  iop,
  input  logic        istart,
  input  logic [31:0] iA1,
  input  logic [31:0] iA2,
  output logic [31:0] oHI,
  output logic [31:0] oLO,
  output logic        obusy,
  output logic        ooccupy
);

  localparam logic [3:0] CNT_MULT = 4'(MULT_CYCLES);
  localparam logic [3:0] CNT_DIV  = 4'(DIV_CYCLES);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic        pvalid_q, pvalid_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  md_cls_e     cls_s;
  logic [63:0] res_s;
  logic        div_zero_s;

  assign cls_s = md_classify(iop);

  md_arith u_arith (
    .iop       (iop),
    .iA1       (iA1),
    .iA2       (iA2),
    .iHI       (hi_q),
    .iLO       (lo_q),
    .ores      (res_s),
    .odiv_zero (div_zero_s)
  );

  assign oHI     = hi_q;
  assign oLO     = lo_q;
  assign obusy   = busy_q;
  assign ooccupy = istart | busy_q;

  // Next-state: count down while running, otherwise launch or move on istart.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    phi_d    = phi_q;
    plo_d    = plo_q;
    pvalid_d = pvalid_q;
    cnt_d    = cnt_q;
    if (cnt_q != 4'd0) begin
      // Starts arriving while running are ignored.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        pvalid_d = 1'b0;
        if (pvalid_q) begin
          hi_d = phi_q;
          lo_d = plo_q;
        end else begin
          hi_d = hi_q;
        end
      end else begin
        pvalid_d = pvalid_q;
      end
    end else if (istart) begin
      case (cls_s)
        CLS_MUL: begin
          phi_d    = res_s[63:32];
          plo_d    = res_s[31:0];
          pvalid_d = 1'b1;
          cnt_d    = CNT_MULT;
        end
        CLS_DIV: begin
          phi_d    = res_s[63:32];
          plo_d    = res_s[31:0];
          // Divide by zero still takes the full latency but leaves HI/LO alone.
          pvalid_d = ~div_zero_s;
          cnt_d    = CNT_DIV;
        end
        CLS_MTHI: hi_d = iA1;
        CLS_MTLO: lo_d = iA1;
        default:  cnt_d = cnt_q;
      endcase
    end else begin
      cnt_d = cnt_q;
    end
    busy_d = (cnt_d != 4'd0);
  end

  // State registers with synchronous active-low reset; reset drops any pending result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      phi_q    <= 32'd0;
      plo_q    <= 32'd0;
      pvalid_q <= 1'b0;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      phi_q    <= phi_d;
      plo_q    <= plo_d;
      pvalid_q <= pvalid_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule
